// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default constants for the pc_seq fetch sequencer
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int PC_D           = 12;
    localparam int PC_STACK_DEPTH = 4;
    localparam int PC_CNT_W       = 16;
    localparam int PC_RESET_ADDR  = 0;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - LIFO of return addresses with push, pop, clear, full and empty
module ret_stack #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [D-1:0]   r_mem [DEPTH];
    logic [PTR_W:0] r_sp;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_sp == (PTR_W+1)'(DEPTH));
    assign empty     = (r_sp == '0);
    assign w_top_idx = PTR_W'(r_sp - 1'b1);
    assign top_data  = r_mem[w_top_idx];
    // Overflowing pushes and underflowing pops are dropped; the caller flags them.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Stack pointer counts live entries; reset and clear both empty the stack.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + 1'b1;
        end else if (w_do_pop) begin
            r_sp <= r_sp - 1'b1;
        end
    end

    // Entry storage is written at the current pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (!reset && !clear && w_do_push) begin
            r_mem[r_sp[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - fetch-stage program-counter sequencer; return stack built only with PC_CALL_STACK_EN
module pc_seq
    import pc_pkg::*;
#(
    parameter int D           = PC_D,
    parameter int STACK_DEPTH = PC_STACK_DEPTH,
    parameter int CNT_W       = PC_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             taken,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic             halt_en,
    input  logic [D-1:0]     target,
    output logic [D-1:0]     prog_ctr,
    output logic             fetch_valid,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             stack_err
);

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    logic [D-1:0]     r_pc;
    logic [D-1:0]     w_pc_nxt;
    logic [D-1:0]     w_pc_inc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_sat;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_clear;

    assign w_pc_inc  = r_pc + 1'b1;
    assign w_cnt_sat = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef PC_CALL_STACK_EN
    logic [D-1:0] w_stk_top;
    logic         w_stk_full;
    logic         w_stk_empty;

    ret_stack #(
        .D     (D),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_stk_top),
        .full      (w_stk_full),
        .empty     (w_stk_empty)
    );
`else
    logic w_unused_stack;
    assign w_unused_stack = w_push ^ w_pop ^ w_clear ^ (STACK_DEPTH == 0);
`endif

    // Next state, next PC, retire count and stack control from strict-priority decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = D'(PC_RESET_ADDR);
                end
            end
            RUN: begin
                if (!stall) begin
                    if (halt_en) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_cnt_nxt = w_cnt_sat;
                        if (ret_en) begin
`ifdef PC_CALL_STACK_EN
                            if (w_stk_empty) begin
                                w_pc_nxt  = w_pc_inc;
                                w_err_nxt = 1'b1;
                            end else begin
                                w_pc_nxt = w_stk_top;
                                w_pop    = 1'b1;
                            end
`else
                            w_pc_nxt = w_pc_inc;
`endif
                        end else if (call_en) begin
`ifdef PC_CALL_STACK_EN
                            if (w_stk_full) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_push = 1'b1;
                            end
`endif
                            w_pc_nxt = target;
                        end else if (branch_en && taken) begin
                            w_pc_nxt = target;
                        end else begin
                            w_pc_nxt = w_pc_inc;
                        end
                    end
                end
            end
            HALT: begin
                // Restart from HALT ignores stall and wipes all run history.
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = D'(PC_RESET_ADDR);
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, retire counter and sticky stack error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= D'(PC_RESET_ADDR);
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign prog_ctr    = r_pc;
    assign fetch_valid = (r_state == RUN);
    assign done        = (r_state == HALT);
    assign instr_cnt   = r_cnt;
`ifdef PC_CALL_STACK_EN
    assign stack_err   = r_err;
`else
    assign stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - randomized scoreboard bench for pc_seq against a behavioural model
module tb_pc_seq;
    import pc_pkg::*;

    localparam int TD  = PC_D;
    localparam int TSD = PC_STACK_DEPTH;
    localparam int TCW = PC_CNT_W;

    typedef struct packed {
        logic [TD-1:0]  pc;
        logic           fv;
        logic           dn;
        logic [TCW-1:0] cnt;
        logic           err;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           stall = 1'b0;
    logic           branch_en = 1'b0;
    logic           taken = 1'b0;
    logic           call_en = 1'b0;
    logic           ret_en = 1'b0;
    logic           halt_en = 1'b0;
    logic [TD-1:0]  target = '0;
    logic [TD-1:0]  prog_ctr;
    logic           fetch_valid;
    logic           done;
    logic [TCW-1:0] instr_cnt;
    logic           stack_err;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Model state: 0 idle, 1 running, 2 halted
    int m_mode = 0;
    int m_pc = 0;
    int m_cnt = 0;
    int m_err = 0;
    int m_stk[$];

    pc_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .branch_en   (branch_en),
        .taken       (taken),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .halt_en     (halt_en),
        .target      (target),
        .prog_ctr    (prog_ctr),
        .fetch_valid (fetch_valid),
        .done        (done),
        .instr_cnt   (instr_cnt),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    function automatic int wrap_pc(input int v);
        return v % (1 << TD);
    endfunction

    task automatic model_update();
        int cnt_max;
        cnt_max = (1 << TCW) - 1;
        if (reset) begin
            m_mode = 0; m_pc = 0; m_cnt = 0; m_err = 0; m_stk.delete();
        end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_pc = 0; end
        end else if (m_mode == 2) begin
            if (start) begin
                m_mode = 1; m_pc = 0; m_cnt = 0; m_err = 0; m_stk.delete();
            end
        end else if (!stall) begin
            if (halt_en) begin
                m_mode = 2;
            end else begin
                if (m_cnt < cnt_max) m_cnt++;
                if (ret_en) begin
`ifdef PC_CALL_STACK_EN
                    if (m_stk.size() == 0) begin
                        m_pc = wrap_pc(m_pc + 1); m_err = 1;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
`else
                    m_pc = wrap_pc(m_pc + 1);
`endif
                end else if (call_en) begin
`ifdef PC_CALL_STACK_EN
                    if (m_stk.size() == TSD) m_err = 1;
                    else m_stk.push_back(wrap_pc(m_pc + 1));
`endif
                    m_pc = int'(target);
                end else if (branch_en && taken) begin
                    m_pc = int'(target);
                end else begin
                    m_pc = wrap_pc(m_pc + 1);
                end
            end
        end
    endtask

    task automatic step(input logic rs, input logic st, input logic sl, input logic br,
                        input logic tk, input logic ca, input logic re, input logic ha,
                        input int tg);
        exp_t e;
        @(negedge clk);
        reset = rs; start = st; stall = sl; branch_en = br; taken = tk;
        call_en = ca; ret_en = re; halt_en = ha; target = TD'(tg);
        model_update();
        e.pc  = TD'(m_pc);
        e.fv  = (m_mode == 1);
        e.dn  = (m_mode == 2);
        e.cnt = TCW'(m_cnt);
        e.err = m_err[0];
        exp_q.push_back(e);
    endtask

    task automatic nop();        step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic jump(int t);  step(0, 0, 0, 1, 1, 0, 0, 0, t); endtask
    task automatic call(int t);  step(0, 0, 0, 0, 0, 1, 0, 0, t); endtask
    task automatic ret();        step(0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic rst_start();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every registered output set against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (prog_ctr !== e.pc || fetch_valid !== e.fv || done !== e.dn ||
                    instr_cnt !== e.cnt || stack_err !== e.err) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual pc=%0d fv=%0b done=%0b cnt=%0d err=%0b required pc=%0d fv=%0b done=%0b cnt=%0d err=%0b",
                             $time, prog_ctr, fetch_valid, done, instr_cnt, stack_err,
                             e.pc, e.fv, e.dn, e.cnt, e.err);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then a long randomized run
    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 1, 0, 0, 77);
        nop();                                   // IDLE ignores controls
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) nop();                        // pc 1..5, cnt 5
        rst_start();
        repeat (3) nop();
        step(0, 0, 0, 1, 1, 0, 0, 0, 247);       // taken -> 247
        rst_start();
        repeat (3) nop();
        step(0, 0, 0, 1, 0, 0, 0, 0, 247);       // not taken -> 4
        repeat (6) nop();                        // pc 10
        call(35);
        repeat (5) nop();                        // pc 40
        ret();                                   // -> 11
        jump(10);
        call(35);
        jump(40);
        repeat (3) step(0, 0, 1, 0, 0, 0, 1, 0, 0);
        ret();
        rst_start();
        call(100); call(200); call(300); call(400); call(500);
        repeat (5) ret();
        jump(6);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);         // halt at 6
        for (int i = 0; i < 10; i++)
            step(0, 0, i[0], 1, 1, 1, 0, 0, 99);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);         // start overrides stall in HALT
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);         // start in RUN ignored
        jump((1 << TD) - 1);
        nop();                                   // wrap to 0
        nop();
        step(1, 1, 0, 1, 1, 0, 0, 0, 5);         // reset mid-run
        nop();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0,
                 int'($urandom_range(0, (1 << TD) - 1)));
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
